// File: rtl/misc_pkg.sv
// Shared types and sizing helpers for the Misc unit's k_sort reader.
// KSORT_K matches the sorter depth so both ends agree by default.
package misc_pkg;

  localparam int KSORT_K = 20;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } drain_state_e;

  function automatic int cnt_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic int num_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/ksort_drain.sv
// Snapshots the k_sort output array on start and streams the first N
// entries with their rank over valid/ready, optionally clearing k_sort.
module ksort_drain
  import misc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = KSORT_K
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [num_w(K)-1:0]   num_out,
  input  logic                  rev,
  input  logic                  clear_after,
  input  logic [WIDTH-1:0]      in_ksort [K-1:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [cnt_w(K)-1:0]   out_rank,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  clear_ksort
);

  localparam int CW = cnt_w(K);
  localparam int NW = num_w(K);

  drain_state_e state_q, state_d;

  logic [WIDTH-1:0] snap [K-1:0];
  logic             rev_q;
  logic             clr_q;
  logic [CW-1:0]    nm1_q;

  logic [NW-1:0]    n_sel;
  logic [CW-1:0]    n_m1;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    idx_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (out_ready && out_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero or oversized requests mean "drain everything".
  always_comb begin
    n_sel = num_out;
    if (num_out == '0 || num_out > NW'(K)) n_sel = NW'(K);
    n_m1   = CW'(n_sel - 1'b1);
    cnt_nx = out_rank + 1'b1;
    idx_nx = rev_q ? CW'(K - 1) - cnt_nx : cnt_nx;
  end

  // out_rank doubles as the beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) snap[i] <= '0;
      rev_q    <= 1'b0;
      clr_q    <= 1'b0;
      nm1_q    <= '0;
      out_data <= '0;
      out_rank <= '0;
      out_last <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            snap     <= in_ksort;
            rev_q    <= rev;
            clr_q    <= clear_after;
            nm1_q    <= n_m1;
            out_data <= rev ? in_ksort[K-1] : in_ksort[0];
            out_rank <= '0;
            out_last <= (n_m1 == '0);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_data <= '0;
              out_rank <= '0;
              out_last <= 1'b0;
            end else begin
              out_data <= snap[idx_nx];
              out_rank <= cnt_nx;
              out_last <= (cnt_nx == nm1_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = (state_q == SEND);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign clear_ksort = (state_q == FIN) && clr_q;

endmodule

// File: doc/ksort_drain.md
Name: ksort_drain

Overview:
- Reader end of the k_sort result interface in the Misc unit.
- On a start pulse, snapshots the K-entry parallel k_sort output array.
- Streams the first N entries out serially over a valid/ready handshake, each tagged with its rank.
- On completion, optionally pulses the k_sort clear so the next kNN query starts from an empty sorter.

Parameters:
- WIDTH, 32, bit width of each sorted entry.
- K, 20, number of entries in the k_sort output array (K >= 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to snapshot in_ksort and begin draining.
- num_out  input  $clog2(K+1)  number of entries to emit, sampled on accepted start; 0 or >K means K.
- rev  input  1  sampled on start; 0 emits entry 0 upward, 1 emits entry K-1 downward.
- clear_after  input  1  sampled on start; 1 requests a clear_ksort pulse at completion.
- in_ksort[K-1:0]  input  WIDTH each  parallel sorted array from k_sort.
- out_valid  output  1  out_data and out_rank are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  WIDTH  current entry.
- out_rank  output  $clog2(K)  emission position 0..N-1 (not the array index).
- out_last  output  1  current beat is the final one (rank N-1).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last beat is accepted.
- clear_ksort  output  1  one-cycle pulse coincident with done when clear_after was set; drives k_sort clear_reg.

Behaviour:
- Reset (rst_n low at a clk edge) is synchronous, active-low. All outputs go to 0, the state goes to IDLE, and the snapshot registers go to 0. Reset mid-drain aborts with no done pulse.
- States: IDLE, SEND, FIN.
- IDLE:
  - out_valid=0, busy=0.
  - start=1: capture in_ksort into the snapshot, latch rev and clear_after, latch n = (num_out==0 || num_out>K) ? K : num_out, set cnt=0, go to SEND.
- SEND:
  - busy=1, out_valid=1.
  - out_data = snap[rev ? K-1-cnt : cnt]; out_rank=cnt; out_last=(cnt==n-1).
  - out_valid&out_ready with out_last: go to FIN.
  - out_valid&out_ready otherwise: cnt++.
  - No ready: hold all outputs stable. out_valid must never drop before acceptance.
- FIN:
  - out_valid=0, done=1, clear_ksort=clear_after_latched, busy=1; next cycle go to IDLE.
- Latency:
  - Start accepted at edge t; first beat valid in cycle t+1.
  - With out_ready held high, one beat per cycle; done is high in cycle t+n+1.
- start while busy (SEND or FIN) is ignored, and the snapshot is not disturbed.
- start in the same cycle as done/FIN is ignored. A new start is accepted only in IDLE.
- Changes on in_ksort after capture have no effect on the stream. The clear pulse therefore cannot corrupt data in flight.
- out_data, out_rank and out_last are registered. They change only on acceptance or state entry, and are 0 in IDLE and FIN.
- cnt is $clog2(K) wide and never exceeds n-1; there is no wrap.

Decomposition:
- misc_pkg: state enum (IDLE, SEND, FIN).
- misc_pkg: constant functions for the count and rank widths ($clog2(K), $clog2(K+1)).
- misc_pkg: a localparam for the default K shared with k_sort.
- Single module, no sub-module. The snapshot register and the index mux are inline.

Test Plan:
- Reset: hold rst_n=0 two cycles with start=1 -> all outputs 0, busy=0, no beats.
- Basic drain: K=20, in_ksort[i]=100+i, num_out=5, rev=0, out_ready=1 -> beats 100..104 on ranks 0..4 in consecutive cycles; out_last on rank 4; done 1 cycle later; clear_ksort=0.
- Reverse, clamp and clear: num_out=0, rev=1, clear_after=1 -> 20 beats with data 119 down to 100; done and clear_ksort pulse together in one cycle.
- Backpressure: num_out=3 with out_ready toggling 1,0,0,1,0,1 -> data/rank held stable while stalled; exactly 3 beats (100,101,102); done after the third acceptance.
- Snapshot isolation: change in_ksort to all 0xFFFF_FFFF one cycle after start, and pulse start again mid-drain -> original values emitted; second start ignored; busy stays high until done.
- Abort: assert rst_n=0 during rank 2 of 5 -> outputs 0 next cycle, no done pulse; a subsequent start drains normally from rank 0.
